// File: rtl/score_display_ctrl.sv
// Score display controller: accumulates point events, applies them to a 3-digit
// BCD score only during vertical blanking, and composites digit glyphs over the title.
module score_display_ctrl #(
    parameter int DIGIT_X0    = 160,
    parameter int DIGIT_Y0    = 20,
    parameter int DIGIT_W     = 25,
    parameter int DIGIT_PITCH = 26,
    parameter int DIGIT_H     = 40,
    parameter int BLANK_ROW   = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic        valid,
    input  logic        point,
    input  logic        clear,
    input  logic [5:0]  title_rgb,
    input  logic        glyph_on,
    output logic [3:0]  digit_val,
    output logic [4:0]  glyph_x,
    output logic [5:0]  glyph_y,
    output logic [5:0]  rgb,
    output logic [11:0] score_bcd,
    output logic        busy
);

    localparam logic [9:0] X0_C     = 10'(DIGIT_X0);
    localparam logic [9:0] Y0_C     = 10'(DIGIT_Y0);
    localparam logic [9:0] W_C      = 10'(DIGIT_W);
    localparam logic [9:0] H_C      = 10'(DIGIT_H);
    localparam logic [9:0] BLANK_C  = 10'(BLANK_ROW);
    localparam logic [5:0] YELLOW_C = 6'b111100;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        CLEAR      = 2'd2,
        APPLY      = 2'd3
    } state_t;

    state_t      state_r;
    logic [3:0]  pend_r;
    logic        clr_pend_r;
    logic        keep_pt_r;
    logic [11:0] score_r;
    logic        busy_r;
    logic [5:0]  rgb_r;

    logic        blank_s;
    logic [3:0]  pend_inc_s;
    logic [3:0]  pend_apply_s;
    logic [3:0]  pend_clr_s;
    logic        in_y_s;
    logic [5:0]  dy_s;
    logic [4:0]  dx_s [3];
    logic [2:0]  hit_s;
    logic        in_digit_s;

    // BCD increment with ripple carry; holds at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r = {v[11:4], v[3:0] + 4'd1};
        end else if (v[7:4] != 4'd9) begin
            r = {v[11:8], v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[11:8] + 4'd1, 8'h00};
        end
        return r;
    endfunction

    assign blank_s = (row >= BLANK_C);

    // Pending-counter candidates: plain accumulate, apply-cycle, and clear-cycle values.
    always_comb begin
        pend_inc_s = pend_r;
        if (point && (pend_r != 4'hF)) begin
            pend_inc_s = pend_r + 4'd1;
        end else begin
            pend_inc_s = pend_r;
        end
        pend_apply_s = pend_r;
        if (pend_r == 4'd0) begin
            pend_apply_s = pend_inc_s;
        end else if (point) begin
            pend_apply_s = pend_r;
        end else begin
            pend_apply_s = pend_r - 4'd1;
        end
        // A point that arrived together with the clear survives the clear.
        pend_clr_s = {3'd0, point} + {3'd0, keep_pt_r};
    end

    // Score sequencing FSM; score only moves while blank is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pend_r     <= 4'd0;
            clr_pend_r <= 1'b0;
            keep_pt_r  <= 1'b0;
            score_r    <= 12'h000;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pend_r <= pend_inc_s;
                    if (clear) begin
                        clr_pend_r <= 1'b1;
                        keep_pt_r  <= point;
                    end
                    if (point || clear || (pend_r != 4'd0) || clr_pend_r) begin
                        state_r <= WAIT_BLANK;
                        busy_r  <= 1'b1;
                    end
                end
                WAIT_BLANK: begin
                    pend_r <= pend_inc_s;
                    if (clear) begin
                        clr_pend_r <= 1'b1;
                        keep_pt_r  <= point;
                    end
                    if (blank_s) begin
                        state_r <= (clr_pend_r || clear) ? CLEAR : APPLY;
                    end
                end
                CLEAR: begin
                    if (!blank_s) begin
                        pend_r  <= pend_inc_s;
                        state_r <= WAIT_BLANK;
                    end else begin
                        score_r    <= 12'h000;
                        clr_pend_r <= 1'b0;
                        keep_pt_r  <= 1'b0;
                        pend_r     <= pend_clr_s;
                        if (pend_clr_s != 4'd0) begin
                            state_r <= APPLY;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    if (clear) begin
                        clr_pend_r <= 1'b1;
                        keep_pt_r  <= point;
                    end
                    if (!blank_s) begin
                        pend_r  <= pend_inc_s;
                        state_r <= WAIT_BLANK;
                    end else begin
                        if (pend_r != 4'd0) begin
                            score_r <= bcd_inc(score_r);
                        end
                        pend_r <= pend_apply_s;
                        if (clear) begin
                            state_r <= WAIT_BLANK;
                        end else if (pend_apply_s == 4'd0) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_y_s = (row > Y0_C) && (row <= Y0_C + H_C);
    assign dy_s   = 6'(row - Y0_C - 10'd1);

    // Per-digit box hit test and in-box column offset.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dx_s[i]  = 5'(col - X0_C - 10'(i * DIGIT_PITCH) - 10'd1);
            hit_s[i] = in_y_s && (col > X0_C + 10'(i * DIGIT_PITCH))
                              && (col <= X0_C + 10'(i * DIGIT_PITCH) + W_C);
        end
    end

    assign in_digit_s = |hit_s;

    // Glyph-ROM address for the digit under the current pixel.
    always_comb begin
        digit_val = 4'hF;
        glyph_x   = 5'd0;
        glyph_y   = 6'd0;
        if (hit_s[0]) begin
            digit_val = score_r[11:8];
            glyph_x   = dx_s[0];
            glyph_y   = dy_s;
        end else if (hit_s[1]) begin
            digit_val = score_r[7:4];
            glyph_x   = dx_s[1];
            glyph_y   = dy_s;
        end else if (hit_s[2]) begin
            digit_val = score_r[3:0];
            glyph_x   = dx_s[2];
            glyph_y   = dy_s;
        end else begin
            digit_val = 4'hF;
            glyph_x   = 5'd0;
            glyph_y   = 6'd0;
        end
    end

    // Registered compositing of glyph pixels over the title stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_r <= 6'd0;
        end else if (!valid) begin
            rgb_r <= 6'd0;
        end else if (in_digit_s && glyph_on) begin
            rgb_r <= YELLOW_C;
        end else begin
            rgb_r <= title_rgb;
        end
    end

    assign rgb       = rgb_r;
    assign score_bcd = score_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: scoreboard queues hold expected
// score and pixel values, popped and compared as the DUT produces them.
module tb_score_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        valid;
    logic        point;
    logic        clear;
    logic [5:0]  title_rgb;
    logic        glyph_on;
    logic [3:0]  digit_val;
    logic [4:0]  glyph_x;
    logic [5:0]  glyph_y;
    logic [5:0]  rgb;
    logic [11:0] score_bcd;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] exp_score_q [$];
    logic [5:0]  exp_rgb_q   [$];

    localparam int NPX = 11;
    localparam int PX_COL   [NPX] = '{161, 161, 186, 187, 237, 238, 200, 200, 185, 190, 160};
    localparam int PX_ROW   [NPX] = '{ 21,  21,  21,  60,  40,  40,  61,  20,  30,  30,  30};
    localparam int PX_VALID [NPX] = '{  1,   1,   1,   1,   1,   1,   1,   1,   1,   0,   1};
    localparam int PX_GON   [NPX] = '{  1,   0,   1,   1,   1,   1,   1,   1,   1,   1,   1};
    localparam int PX_TITLE [NPX] = '{'h15,'h2A,'h07,'h11,'h22,'h33,'h09,'h0C,'h30,'h3F,'h01};
    localparam int PX_DV    [NPX] = '{  1,   1, 'hF,   2,   3, 'hF, 'hF, 'hF,   1,   2, 'hF};
    localparam int PX_GX    [NPX] = '{  0,   0,   0,   0,  24,   0,   0,   0,  24,   3,   0};
    localparam int PX_GY    [NPX] = '{  0,   0,   0,  39,  19,   0,   0,   0,   9,   9,   0};
    localparam int PX_RGB   [NPX] = '{'h3C,'h2A,'h07,'h3C,'h3C,'h33,'h09,'h0C,'h3C,'h00,'h01};

    always #5 clk = ~clk;

    score_display_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .valid     (valid),
        .point     (point),
        .clear     (clear),
        .title_rgb (title_rgb),
        .glyph_on  (glyph_on),
        .digit_val (digit_val),
        .glyph_x   (glyph_x),
        .glyph_y   (glyph_y),
        .rgb       (rgb),
        .score_bcd (score_bcd),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        point = 1'b0;
        clear = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Deliver n points in bursts of at most 15, each drained during a blank.
    task automatic add_points(input int n);
        int left;
        int b;
        left = n;
        while (left > 0) begin
            b = (left > 15) ? 15 : left;
            row = 10'd100;
            repeat (b) begin
                point = 1'b1;
                tick();
            end
            point = 1'b0;
            tick();
            row = 10'd480;
            wait_idle();
            row = 10'd100;
            left -= b;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        valid     = 1'b1;
        title_rgb = 6'h2A;
        tick();
        vectors++;
        if (rgb !== 6'h00) begin miscompares++; $display("FAIL reset_rgb: got %h, expected 00", rgb); end
        vectors++;
        if (score_bcd !== 12'h000) begin miscompares++; $display("FAIL reset_score: got %h, expected 000", score_bcd); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst_n     = 1'b1;
        title_rgb = 6'h00;
    endtask

    task automatic test_basic();
        logic [11:0] e;
        row = 10'd100;
        point = 1'b1;
        tick();
        point = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_rise: got %b, expected 1", busy); end
        tick();
        repeat (2) begin
            point = 1'b1;
            tick();
            point = 1'b0;
            tick();
        end
        repeat (4) tick();
        vectors++;
        if (score_bcd !== 12'h000) begin miscompares++; $display("FAIL basic_hold: got %h, expected 000", score_bcd); end
        row = 10'd480;
        exp_score_q.push_back(12'h000);
        exp_score_q.push_back(12'h001);
        exp_score_q.push_back(12'h002);
        exp_score_q.push_back(12'h003);
        while (exp_score_q.size() > 0) begin
            tick();
            e = exp_score_q.pop_front();
            vectors++;
            if (score_bcd !== e) begin miscompares++; $display("FAIL basic_seq: got %h, expected %h", score_bcd, e); end
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_fall: got %b, expected 0", busy); end
        row = 10'd100;
    endtask

    task automatic test_saturate();
        do_reset();
        row = 10'd100;
        point = 1'b1;
        repeat (20) tick();
        point = 1'b0;
        tick();
        vectors++;
        if (score_bcd !== 12'h000) begin miscompares++; $display("FAIL sat_hold: got %h, expected 000", score_bcd); end
        row = 10'd480;
        wait_idle();
        vectors++;
        if (score_bcd !== 12'h015) begin miscompares++; $display("FAIL sat_score: got %h, expected 015", score_bcd); end
        row = 10'd100;
    endtask

    task automatic test_carry();
        do_reset();
        add_points(99);
        vectors++;
        if (score_bcd !== 12'h099) begin miscompares++; $display("FAIL carry_099: got %h, expected 099", score_bcd); end
        add_points(1);
        vectors++;
        if (score_bcd !== 12'h100) begin miscompares++; $display("FAIL carry_100: got %h, expected 100", score_bcd); end
        add_points(899);
        vectors++;
        if (score_bcd !== 12'h999) begin miscompares++; $display("FAIL carry_999: got %h, expected 999", score_bcd); end
        add_points(2);
        row = 10'd480;
        repeat (5) tick();
        vectors++;
        if (score_bcd !== 12'h999) begin miscompares++; $display("FAIL sat_999: got %h, expected 999", score_bcd); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_999_idle: got %b, expected 0", busy); end
        row = 10'd100;
    endtask

    task automatic test_clear_point();
        logic [11:0] e;
        do_reset();
        add_points(42);
        vectors++;
        if (score_bcd !== 12'h042) begin miscompares++; $display("FAIL clr_pre: got %h, expected 042", score_bcd); end
        row   = 10'd200;
        clear = 1'b1;
        point = 1'b1;
        tick();
        clear = 1'b0;
        point = 1'b0;
        repeat (3) tick();
        vectors++;
        if (score_bcd !== 12'h042) begin miscompares++; $display("FAIL clr_hold: got %h, expected 042", score_bcd); end
        row = 10'd480;
        exp_score_q.push_back(12'h042);
        exp_score_q.push_back(12'h000);
        exp_score_q.push_back(12'h001);
        while (exp_score_q.size() > 0) begin
            tick();
            e = exp_score_q.pop_front();
            vectors++;
            if (score_bcd !== e) begin miscompares++; $display("FAIL clr_seq: got %h, expected %h", score_bcd, e); end
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy: got %b, expected 0", busy); end
        row = 10'd100;
    endtask

    // Back-to-back pixel stream; score is 123 so each digit is distinguishable.
    task automatic test_pixel();
        logic [5:0] e;
        do_reset();
        add_points(123);
        vectors++;
        if (score_bcd !== 12'h123) begin miscompares++; $display("FAIL px_score: got %h, expected 123", score_bcd); end
        for (int i = 0; i < NPX; i++) begin
            col       = 10'(PX_COL[i]);
            row       = 10'(PX_ROW[i]);
            valid     = 1'(PX_VALID[i]);
            glyph_on  = 1'(PX_GON[i]);
            title_rgb = 6'(PX_TITLE[i]);
            exp_rgb_q.push_back(6'(PX_RGB[i]));
            #1;
            vectors++;
            if (digit_val !== 4'(PX_DV[i])) begin miscompares++; $display("FAIL px_digit[%0d]: got %h, expected %h", i, digit_val, 4'(PX_DV[i])); end
            vectors++;
            if (glyph_x !== 5'(PX_GX[i])) begin miscompares++; $display("FAIL px_gx[%0d]: got %0d, expected %0d", i, glyph_x, PX_GX[i]); end
            vectors++;
            if (glyph_y !== 6'(PX_GY[i])) begin miscompares++; $display("FAIL px_gy[%0d]: got %0d, expected %0d", i, glyph_y, PX_GY[i]); end
            tick();
            e = exp_rgb_q.pop_front();
            vectors++;
            if (rgb !== e) begin miscompares++; $display("FAIL px_rgb[%0d]: got %h, expected %h", i, rgb, e); end
        end
        valid    = 1'b1;
        glyph_on = 1'b0;
        col      = 10'd0;
        row      = 10'd100;
    endtask

    task automatic test_reset_mid_apply();
        do_reset();
        valid     = 1'b1;
        col       = 10'd0;
        title_rgb = 6'h2A;
        row       = 10'd100;
        point     = 1'b1;
        repeat (8) tick();
        point = 1'b0;
        tick();
        row = 10'd480;
        repeat (4) tick();
        vectors++;
        if (score_bcd !== 12'h003) begin miscompares++; $display("FAIL mid_pre_score: got %h, expected 003", score_bcd); end
        vectors++;
        if (rgb !== 6'h2A) begin miscompares++; $display("FAIL mid_pre_rgb: got %h, expected 2a", rgb); end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (score_bcd !== 12'h000) begin miscompares++; $display("FAIL mid_rst_score: got %h, expected 000", score_bcd); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b, expected 0", busy); end
        vectors++;
        if (rgb !== 6'h00) begin miscompares++; $display("FAIL mid_rst_rgb: got %h, expected 00", rgb); end
        rst_n = 1'b1;
        repeat (10) tick();
        vectors++;
        if (score_bcd !== 12'h000) begin miscompares++; $display("FAIL mid_post_score: got %h, expected 000", score_bcd); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_post_busy: got %b, expected 0", busy); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        col       = 10'd0;
        row       = 10'd0;
        valid     = 1'b1;
        point     = 1'b0;
        clear     = 1'b0;
        title_rgb = 6'h00;
        glyph_on  = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_carry();
        test_clear_point();
        test_pixel();
        test_reset_mid_apply();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
